// File: rtl/wb_stage.sv
// ============================================================================
// wb_stage: writeback stage with a two-entry (head + skid) result buffer, load
// extraction/extension and a retire counter. Optional bypass: WB_BYPASS_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module wb_stage #(
    parameter int XLEN  = 32,
    parameter int RADDR = 5,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [RADDR-1:0] in_rd,
    input  logic             in_regwrite,
    input  logic             in_memtoreg,
    input  logic [2:0]       in_funct3,
    input  logic [XLEN-1:0]  in_aluresult,
    input  logic [XLEN-1:0]  in_memdata,
    output logic             rf_we,
    output logic [RADDR-1:0] rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    input  logic             rf_ready,
    output logic [CNT_W-1:0] retire_count,
    output logic             byp_valid,
    output logic [RADDR-1:0] byp_rd,
    output logic [XLEN-1:0]  byp_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state;
    logic             skid_wr;
    logic [RADDR-1:0] skid_rd;
    logic [XLEN-1:0]  skid_data;

    logic [1:0]       off;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [XLEN-1:0]  cap_data;
    logic             cap_wr;
    logic             push;
    logic             pop;

    assign off     = in_aluresult[1:0];
    assign ld_byte = in_memdata[{off, 3'b000} +: 8];
    assign ld_half = in_memdata[{off[1], 4'b0000} +: 16];

    always_comb begin
        cap_data = in_aluresult;
        if (in_memtoreg) begin
            case (in_funct3)
                3'b000:  cap_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
                3'b100:  cap_data = {{(XLEN-8){1'b0}}, ld_byte};
                3'b001:  cap_data = {{(XLEN-16){ld_half[15]}}, ld_half};
                3'b101:  cap_data = {{(XLEN-16){1'b0}}, ld_half};
                default: cap_data = in_memdata;
            endcase
        end
    end

    // Writes to x0 and non-writing entries never need the register-file grant.
    assign cap_wr = in_regwrite && (in_rd != '0);
    assign push   = in_valid && in_ready;
    assign pop    = (state != EMPTY) && (rf_ready || !rf_we);

    // rf_we/rf_waddr/rf_wdata are the head entry itself; rf_we is cleared when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            in_ready     <= 1'b1;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            skid_wr      <= 1'b0;
            skid_rd      <= '0;
            skid_data    <= '0;
            retire_count <= '0;
        end else begin
            if (pop) begin
                retire_count <= retire_count + CNT_W'(1);
            end
            case (state)
                EMPTY: begin
                    if (push) begin
                        rf_we    <= cap_wr;
                        rf_waddr <= in_rd;
                        rf_wdata <= cap_data;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        rf_we    <= cap_wr;
                        rf_waddr <= in_rd;
                        rf_wdata <= cap_data;
                    end else if (push) begin
                        skid_wr   <= cap_wr;
                        skid_rd   <= in_rd;
                        skid_data <= cap_data;
                        state     <= TWO;
                        in_ready  <= 1'b0;
                    end else if (pop) begin
                        rf_we <= 1'b0;
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        rf_we    <= skid_wr;
                        rf_waddr <= skid_rd;
                        rf_wdata <= skid_data;
                        state    <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    rf_we    <= 1'b0;
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid = rf_we;
    assign byp_rd    = rf_waddr;
    assign byp_data  = rf_wdata;
`else
    assign byp_valid = 1'b0;
    assign byp_rd    = '0;
    assign byp_data  = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wb_stage.sv
// ============================================================================
// tb_wb_stage: vector table plus hand sequences, checked by a queue scoreboard.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_regwrite;
    logic        in_memtoreg;
    logic [2:0]  in_funct3;
    logic [31:0] in_aluresult;
    logic [31:0] in_memdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        rf_ready;
    logic [31:0] retire_count;
    logic        byp_valid;
    logic [4:0]  byp_rd;
    logic [31:0] byp_data;

    wb_stage #(.XLEN(32), .RADDR(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .in_funct3(in_funct3), .in_aluresult(in_aluresult), .in_memdata(in_memdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
        .retire_count(retire_count),
        .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] mem;
        logic [31:0] exp;
        logic        ewr;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        wr;
    } ent_t;

    vec_t        vecs [14];
    ent_t        sb [$];
    int          total = 0;
    int          bad   = 0;
    int          exp_count = 0;
    logic [31:0] cur_exp = '0;
    logic        cur_wr  = 1'b0;
    logic        byp_on;

`ifdef WB_BYPASS_EN
    initial byp_on = 1'b1;
`else
    initial byp_on = 1'b0;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue of accepted entries, popped on grant or when non-writing.
    always @(negedge clk) begin
        ent_t e;
        if (!rst_n) begin
            sb.delete();
            exp_count = 0;
        end else begin
            check("sb_in_ready", in_ready, sb.size() < 2);
            check("sb_count", retire_count, exp_count);
            if (sb.size() == 0) begin
                check("sb_rf_we_idle", rf_we, 0);
                check("sb_byp_idle", byp_valid, 0);
            end else begin
                check("sb_rf_we", rf_we, sb[0].wr);
                check("sb_byp_valid", byp_valid, byp_on & sb[0].wr);
                if (sb[0].wr) begin
                    check("sb_waddr", rf_waddr, sb[0].rd);
                    check("sb_wdata", rf_wdata, sb[0].data);
                    check("sb_byp_rd", byp_rd, byp_on ? sb[0].rd : 5'd0);
                    check("sb_byp_data", byp_data, byp_on ? sb[0].data : 32'd0);
                end
                if (!sb[0].wr || rf_ready) begin
                    void'(sb.pop_front());
                    exp_count++;
                end
            end
            if (in_valid && in_ready) begin
                e.rd   = in_rd;
                e.data = cur_exp;
                e.wr   = cur_wr;
                sb.push_back(e);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input vec_t v);
        logic acc;
        in_valid     = 1'b1;
        in_rd        = v.rd;
        in_regwrite  = v.rw;
        in_memtoreg  = v.m2r;
        in_funct3    = v.f3;
        in_aluresult = v.alu;
        in_memdata   = v.mem;
        cur_exp      = v.exp;
        cur_wr       = v.ewr;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("send_accept", acc, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string nm);
        check({nm, "_rf_we"}, rf_we, 0);
        check({nm, "_waddr"}, rf_waddr, 0);
        check({nm, "_wdata"}, rf_wdata, 0);
        check({nm, "_count"}, retire_count, 0);
        check({nm, "_byp_valid"}, byp_valid, 0);
        check({nm, "_byp_data"}, byp_data, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        vec_t a;
        vec_t b;
        vec_t cc;
        vecs[0]  = '{5'd5,  1'b1, 1'b0, 3'b000, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 1'b1};
        vecs[1]  = '{5'd3,  1'b1, 1'b1, 3'b000, 32'h0000_0003, 32'h80FF_7F01, 32'hFFFF_FF80, 1'b1};
        vecs[2]  = '{5'd3,  1'b1, 1'b1, 3'b100, 32'h0000_0003, 32'h80FF_7F01, 32'h0000_0080, 1'b1};
        vecs[3]  = '{5'd4,  1'b1, 1'b1, 3'b001, 32'h0000_0002, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b1};
        vecs[4]  = '{5'd4,  1'b1, 1'b1, 3'b101, 32'h0000_0002, 32'h80FF_7F01, 32'h0000_80FF, 1'b1};
        vecs[5]  = '{5'd6,  1'b1, 1'b1, 3'b010, 32'h0000_0001, 32'h80FF_7F01, 32'h80FF_7F01, 1'b1};
        vecs[6]  = '{5'd6,  1'b1, 1'b1, 3'b001, 32'h0000_0003, 32'h80FF_7F01, 32'hFFFF_80FF, 1'b1};
        vecs[7]  = '{5'd7,  1'b1, 1'b1, 3'b000, 32'h0000_0000, 32'h80FF_7F01, 32'h0000_0001, 1'b1};
        vecs[8]  = '{5'd7,  1'b1, 1'b1, 3'b000, 32'h0000_0001, 32'h80FF_7F01, 32'h0000_007F, 1'b1};
        vecs[9]  = '{5'd8,  1'b1, 1'b1, 3'b100, 32'h0000_0002, 32'h80FF_7F01, 32'h0000_00FF, 1'b1};
        vecs[10] = '{5'd9,  1'b1, 1'b1, 3'b001, 32'h0000_0000, 32'h80FF_7F01, 32'h0000_7F01, 1'b1};
        vecs[11] = '{5'd9,  1'b1, 1'b1, 3'b111, 32'h0000_0000, 32'h80FF_7F01, 32'h80FF_7F01, 1'b1};
        vecs[12] = '{5'd0,  1'b1, 1'b0, 3'b000, 32'h0000_DEAD, 32'h0000_0000, 32'h0000_DEAD, 1'b0};
        vecs[13] = '{5'd10, 1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_rd = '0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
        in_funct3 = '0; in_aluresult = '0; in_memdata = '0; rf_ready = 1'b1;
        #1;
        check_zero_outputs("reset");
        idle(2);
        rst_n = 1'b1;
        check("reset_in_ready", in_ready, 1);

        for (int i = 0; i < 14; i++) begin
            send(vecs[i]);
            @(negedge clk);
            check("vec_rf_we", rf_we, vecs[i].ewr);
            if (vecs[i].ewr) check("vec_wdata", rf_wdata, vecs[i].exp);
            check("vec_count", retire_count, i);
            @(posedge clk);
            #1;
        end
        idle(2);

        // Backpressure: grant withheld for 3 cycles while 3 results are offered.
        a  = '{5'd11, 1'b1, 1'b0, 3'b000, 32'h0000_0A0A, 32'h0, 32'h0000_0A0A, 1'b1};
        b  = '{5'd12, 1'b1, 1'b0, 3'b000, 32'h0000_0B0B, 32'h0, 32'h0000_0B0B, 1'b1};
        cc = '{5'd13, 1'b1, 1'b0, 3'b000, 32'h0000_0C0C, 32'h0, 32'h0000_0C0C, 1'b1};
        rf_ready = 1'b0;
        fork
            begin
                send(a);
                send(b);
                send(cc);
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                check("bp_in_ready_low", in_ready, 0);
                check("bp_waddr_hold", rf_waddr, 11);
                @(posedge clk);
                @(negedge clk);
                check("bp_waddr_stable", rf_waddr, 11);
                check("bp_wdata_stable", rf_wdata, 32'h0000_0A0A);
                @(posedge clk);
                #1;
                rf_ready = 1'b1;
            end
        join
        idle(4);

        // x0 write retires without a grant.
        rf_ready = 1'b0;
        send('{5'd0, 1'b1, 1'b0, 3'b000, 32'h0000_0099, 32'h0, 32'h0000_0099, 1'b0});
        @(negedge clk);
        check("x0_rf_we", rf_we, 0);
        c = retire_count;
        @(posedge clk);
        @(negedge clk);
        check("x0_count", retire_count, c + 1);
        @(posedge clk);
        #1;

        // Load held without grant: bypass mirrors the write port every held cycle.
        send('{5'd7, 1'b1, 1'b1, 3'b100, 32'h0000_0003, 32'h80FF_7F01, 32'h0000_0080, 1'b1});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("byp_valid_hold", byp_valid, byp_on);
            check("byp_rd_hold", byp_rd, byp_on ? 5'd7 : 5'd0);
            check("byp_data_hold", byp_data, byp_on ? 32'h0000_0080 : 32'd0);
            check("byp_wdata_hold", rf_wdata, 32'h0000_0080);
            @(posedge clk);
            #1;
        end
        rf_ready = 1'b1;
        idle(3);

        // Reset while two entries are buffered.
        rf_ready = 1'b0;
        send(a);
        send(b);
        @(negedge clk);
        check("two_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("midrst");
        @(posedge clk);
        #1;
        rf_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_rst_rf_we", rf_we, 0);
            check("post_rst_count", retire_count, 0);
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
